pulse_period_meter: RTL and testbench

Measures the period and high time of a periodic single-bit tick, such as the one produced by the mode-selectable tick generator in the oscilloscope datapath. It classifies the measured period back into the generator mode code (CONT/DISP/BLINK) and flags a missing or stalled tick. It sits on the consumer side of the tick: it drives mode-consistency checks, the display-refresh watchdog, and on-board self-test.

---
 rtl/pulse_period_meter.sv | 120 ++++++++++++
 tb/tb_pulse_period_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Period / high-time meter for a periodic tick, with mode classification and stall timeout.
// Optional feature macro: PULSE_SYNC_EN (two-flop input synchronizer ahead of edge detect).
module pulse_period_meter #(
  parameter int unsigned      WIDTH   = 24,
  parameter logic [WIDTH-1:0] P_CONT  = 24'd1000001,
  parameter logic [WIDTH-1:0] P_DISP  = 24'd100001,
  parameter logic [WIDTH-1:0] P_BLINK = 24'd5000001,
  parameter logic [WIDTH-1:0] TOL     = 24'd0,
  parameter logic [WIDTH-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic [7:0]       high_time,
  output logic             period_valid,
  output logic [1:0]       modo_det,
  output logic             timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [7:0]       hcnt, hshadow;
  logic             fell;
  logic             p_s, pulse_d, rise, fall;
  logic [1:0]       mode_nxt;

`ifdef PULSE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk_in) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], pulse_in};
  end
  assign p_s = sync_q[1];
`else
  assign p_s = pulse_in;
`endif

  assign rise = p_s & ~pulse_d;
  assign fall = ~p_s & pulse_d;

  // |c - p| <= TOL evaluated one bit wider so the difference never wraps
  function automatic logic in_tol(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] p);
    logic [WIDTH:0] d;
    d = (c >= p) ? ({1'b0, c} - {1'b0, p}) : ({1'b0, p} - {1'b0, c});
    return d <= {1'b0, TOL};
  endfunction

  always_comb begin
    mode_nxt = 2'b11;
    if      (in_tol(cnt, P_CONT))  mode_nxt = 2'b00;
    else if (in_tol(cnt, P_DISP))  mode_nxt = 2'b01;
    else if (in_tol(cnt, P_BLINK)) mode_nxt = 2'b10;
  end

  // High-phase counter; fell marks that the shadow holds a completed pulse
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pulse_d <= 1'b0;
      hcnt    <= '0;
      hshadow <= '0;
      fell    <= 1'b0;
    end else begin
      pulse_d <= p_s;
      if (rise) begin
        hcnt <= 8'd1;
        fell <= 1'b0;
      end else if (p_s && hcnt != 8'hFF) begin
        hcnt <= hcnt + 8'd1;
      end
      if (fall) begin
        hshadow <= hcnt;
        fell    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      modo_det     <= 2'b11;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= WIDTH'(1);
          end
        end
        MEASURE: begin
          // a rise landing on cnt == TIMEOUT still counts as a valid period
          if (rise) begin
            period       <= cnt;
            cnt          <= WIDTH'(1);
            high_time    <= fell ? hshadow : 8'hFF;
            modo_det     <= mode_nxt;
            period_valid <= 1'b1;
            timeout      <= 1'b0;
          end else if (cnt == TIMEOUT) begin
            state    <= IDLE;
            timeout  <= 1'b1;
            modo_det <= 2'b11;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: three instances (TOL=0, TOL=1, TIMEOUT=50) share one tick,
// checked against a pulse-level reference model plus a hand-filled vector table.
module tb_pulse_period_meter;
  localparam int ND = 3;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_in = 1'b0;
  logic [23:0] per [ND];
  logic [7:0]  ht  [ND];
  logic        pv  [ND];
  logic [1:0]  md  [ND];
  logic        to_o[ND];

  always #5 clk_in = ~clk_in;

  pulse_period_meter #(.P_CONT(24'd1000), .P_DISP(24'd100), .P_BLINK(24'd5000),
                       .TOL(24'd0), .TIMEOUT(24'd6000)) u_a (
    .clk_in(clk_in), .rst(rst), .pulse_in(pulse_in), .period(per[0]), .high_time(ht[0]),
    .period_valid(pv[0]), .modo_det(md[0]), .timeout(to_o[0]));

  pulse_period_meter #(.P_CONT(24'd1000), .P_DISP(24'd100), .P_BLINK(24'd5000),
                       .TOL(24'd1), .TIMEOUT(24'd6000)) u_b (
    .clk_in(clk_in), .rst(rst), .pulse_in(pulse_in), .period(per[1]), .high_time(ht[1]),
    .period_valid(pv[1]), .modo_det(md[1]), .timeout(to_o[1]));

  pulse_period_meter #(.P_CONT(24'd1000), .P_DISP(24'd100), .P_BLINK(24'd5000),
                       .TOL(24'd0), .TIMEOUT(24'd50)) u_c (
    .clk_in(clk_in), .rst(rst), .pulse_in(pulse_in), .period(per[2]), .high_time(ht[2]),
    .period_valid(pv[2]), .modo_det(md[2]), .timeout(to_o[2]));

  int n_chk = 0, n_fail = 0;

  // reference model state, one slot per instance
  int to_p [ND] = '{6000, 6000, 50};
  int tol_p[ND] = '{0, 1, 0};
  bit have [ND];
  int ph   [ND];
  int pp   [ND];
  bit tf   [ND];

  // snapshot of the strobe cycle for the table comparison
  logic        s_pv;
  logic [31:0] s_per, s_ht, s_md0, s_md1;

  typedef struct {
    int h; int p; bit strb; int per; int ht; int md_a; int md_b;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ab(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int cls(input int c, input int tol);
    if (ab(c - 1000) <= tol) return 0;
    if (ab(c - 100)  <= tol) return 1;
    if (ab(c - 5000) <= tol) return 2;
    return 3;
  endfunction

  // One tick: h cycles high, p-h low, starting at a negedge. Checks every instance.
  task automatic send(input int h, input int p);
    bit strb[ND];
    int extra = 0;
    for (int d = 0; d < ND; d++) strb[d] = have[d] && (pp[d] <= to_p[d]);
    pulse_in = 1'b1;
    for (int j = 1; j <= p; j++) begin
      @(negedge clk_in);
      if (j == 1) begin
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("strobe[%0d]", d), pv[d], strb[d]);
          if (strb[d]) begin
            chk($sformatf("period[%0d]", d), per[d], pp[d]);
            chk($sformatf("high_time[%0d]", d), ht[d], (ph[d] >= 255) ? 255 : ph[d]);
            chk($sformatf("modo[%0d]", d), md[d], cls(pp[d], tol_p[d]));
            chk($sformatf("timeout_clr[%0d]", d), to_o[d], 0);
            tf[d] = 1'b0;
          end
        end
        s_pv = pv[0]; s_per = per[0]; s_ht = ht[0]; s_md0 = md[0]; s_md1 = md[1];
      end else begin
        for (int d = 0; d < ND; d++) if (pv[d]) extra++;
      end
      for (int d = 0; d < ND; d++) begin
        if (j == to_p[d]) chk($sformatf("timeout_pre[%0d]", d), to_o[d], tf[d]);
        if (j == to_p[d] + 1) begin
          tf[d] = 1'b1;
          chk($sformatf("timeout_set[%0d]", d), to_o[d], 1);
          chk($sformatf("timeout_modo[%0d]", d), md[d], 3);
        end
      end
      if (j == h) pulse_in = 1'b0;
    end
    chk("extra_strobes", extra, 0);
    for (int d = 0; d < ND; d++) begin
      have[d] = 1'b1; ph[d] = h; pp[d] = p;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk_in);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_period[%0d]", d), per[d], 0);
      chk($sformatf("rst_high_time[%0d]", d), ht[d], 0);
      chk($sformatf("rst_valid[%0d]", d), pv[d], 0);
      chk($sformatf("rst_modo[%0d]", d), md[d], 3);
      chk($sformatf("rst_timeout[%0d]", d), to_o[d], 0);
      have[d] = 1'b0; tf[d] = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{3,   100,  0, 0,    0,   3, 3},
      '{3,   100,  1, 100,  3,   1, 1},
      '{5,   1000, 1, 100,  3,   1, 1},
      '{1,   5000, 1, 1000, 5,   0, 0},
      '{300, 1001, 1, 5000, 1,   2, 2},
      '{2,   999,  1, 1001, 255, 3, 0},
      '{1,   2,    1, 999,  2,   3, 0},
      '{1,   2,    1, 2,    1,   3, 3},
      '{1,   1002, 1, 2,    1,   3, 3},
      '{4,   100,  1, 1002, 1,   3, 3},
      '{300, 400,  1, 100,  4,   1, 1},
      '{3,   100,  1, 400,  255, 3, 3}
    };
    @(negedge clk_in);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].h, tbl[i].p);
      chk($sformatf("tbl%0d_valid", i), s_pv, tbl[i].strb);
      if (tbl[i].strb) begin
        chk($sformatf("tbl%0d_period", i), s_per, tbl[i].per);
        chk($sformatf("tbl%0d_high_time", i), s_ht, tbl[i].ht);
        chk($sformatf("tbl%0d_modo_tol0", i), s_md0, tbl[i].md_a);
        chk($sformatf("tbl%0d_modo_tol1", i), s_md1, tbl[i].md_b);
      end
    end

    // stall: timeout, rise from IDLE without strobe, then recovery and exact-TIMEOUT periods
    do_reset();
    send(1, 60);
    chk("tmo_flag", to_o[2], 1);
    send(1, 40);
    send(1, 50);
    chk("tmo_cleared", to_o[2], 0);
    chk("tmo_period40", per[2], 40);
    for (int i = 0; i < 3; i++) send(2, 50);
    chk("tmo_period50", per[2], 50);
    chk("tmo_never", to_o[2], 0);

    // reset in the middle of a measurement
    send(3, 100);
    send(3, 100);
    pulse_in = 1'b1;
    repeat (3) @(negedge clk_in);
    pulse_in = 1'b0;
    repeat (20) @(negedge clk_in);
    do_reset();
    send(3, 100);
    send(3, 100);
    send(3, 100);
    chk("post_rst_period", per[0], 100);

    for (int i = 0; i < 40; i++) begin
      int r, p, h;
      r = $urandom_range(0, 9);
      if (r < 2)       p = 99 + $urandom_range(0, 2);
      else if (r == 2) p = 999 + $urandom_range(0, 2);
      else if (r < 7)  p = $urandom_range(2, 80);
      else             p = $urandom_range(2, 400);
      h = $urandom_range(1, p - 1);
      send(h, p);
    end
    send(1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
